apb_mailbox: RTL and testbench



---
 rtl/apb_mailbox_pkg.sv | 44 ++++
 rtl/byte_fifo.sv | 74 +++++++
 rtl/apb_mailbox.sv | 264 ++++++++++++++++++++++++++
 tb/tb_apb_mailbox.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mailbox_pkg.sv
// ---------------------------------------------------------------------------
// apb_mailbox_pkg
// Shared constants for the APB mailbox: register map, STATUS/CTRL bit
// positions, reset values, and a helper that sizes the FIFO level field.
// ---------------------------------------------------------------------------
package apb_mailbox_pkg;

  // Register map (byte addresses inside the 5-bit APB window)
  localparam logic [4:0] ADDR_DATA     = 5'h00;
  localparam logic [4:0] ADDR_STATUS   = 5'h01;
  localparam logic [4:0] ADDR_TX_LEVEL = 5'h02;
  localparam logic [4:0] ADDR_RX_LEVEL = 5'h03;
  localparam logic [4:0] ADDR_CTRL     = 5'h04;
  localparam logic [4:0] ADDR_SCRATCH  = 5'h05;
  localparam logic [4:0] ADDR_ID       = 5'h06;

  // STATUS bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_UNF   = 5;
  localparam int ST_WAIT_TO  = 6;

  // CTRL bit positions
  localparam int CTRL_TX_FLUSH   = 0;
  localparam int CTRL_RX_FLUSH   = 1;
  localparam int CTRL_IRQ_RX_EN  = 2;
  localparam int CTRL_IRQ_TXE_EN = 3;

  // Reset values
  localparam logic [7:0] RST_SCRATCH = 8'h00;
  localparam logic       RST_CTRL_EN = 1'b0;
  localparam logic       RST_FLAG    = 1'b0;
  localparam logic       RST_IRQ     = 1'b0;

  // A FIFO of DEPTH entries needs one extra bit to tell full from empty,
  // which is also the width of its fill level.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous byte FIFO with a registered head. Pointers carry one extra
// bit so full and empty can be told apart without a separate counter.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   flush  in   empty the FIFO at the next edge; push/pop this cycle ignored
//   push   in   write wdata (dropped when full)
//   wdata  in   byte to write
//   pop    in   discard the head (ignored when empty)
//   rdata  out  current head
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   level  out  number of stored entries
// ---------------------------------------------------------------------------
module byte_fifo
  import apb_mailbox_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int LW    = level_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = LW - 1;

  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [7:0]    mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  // Full when the slot indices match but the wrap bits differ.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Fullness/emptiness are judged on the state before this edge, so a push
  // into a full FIFO is dropped even if a pop happens in the same cycle.
  assign push_ok = push & ~full  & ~flush;
  assign pop_ok  = pop  & ~empty & ~flush;

  // Pointer state; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apb_mailbox.sv
// ---------------------------------------------------------------------------
// apb_mailbox
// APB slave mailbox between the I2C-to-APB bridge and the core. The host
// fills a TX byte FIFO that the core drains over a valid/ready stream, and
// drains an RX byte FIFO that the core fills. STATUS, level, CTRL, SCRATCH
// and ID registers plus a registered level interrupt complete the block.
//
// Build option: define APB_MAILBOX_WAIT_EN to stall DATA accesses (PREADY=0)
// while TX is full / RX is empty, bounded by WAIT_LIMIT cycles. Without it
// PREADY is tied high and STATUS.WAIT_TO always reads 0.
//
// Ports:
//   CLK      in   clock
//   RESETn   in   asynchronous active-low reset
//   PSEL     in   APB select
//   PADDR    in   APB byte address (5 bits)
//   PENABLE  in   APB access phase
//   PWRITE   in   1 = write
//   PWDATA   in   write data
//   PRDATA   out  read data during the access phase, 0 otherwise
//   PREADY   out  access completion
//   tx_data  out  TX FIFO head
//   tx_valid out  TX FIFO non-empty (low during a TX flush)
//   tx_ready in   core consumes the head when tx_valid & tx_ready
//   rx_data  in   byte from the core
//   rx_valid in   core offers rx_data
//   rx_ready out  RX FIFO not full
//   irq      out  level interrupt, registered
// ---------------------------------------------------------------------------
module apb_mailbox
  import apb_mailbox_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter int         WAIT_LIMIT = 255
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       PSEL,
  input  logic [4:0] PADDR,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);

  localparam int LW = level_width(DEPTH);

  logic          access;
  logic          ready;
  logic          commit;
  logic          wr_commit;
  logic          rd_commit;
  logic          sel_data;
  logic          sel_status;
  logic          sel_ctrl;
  logic          sel_scratch;

  logic          tx_full;
  logic          tx_empty;
  logic [LW-1:0] tx_level;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_flush_pend;

  logic          rx_full;
  logic          rx_empty;
  logic [LW-1:0] rx_level;
  logic [7:0]    rx_head;
  logic          rx_push;
  logic          rx_pop;
  logic          rx_flush_pend;

  logic          tx_ovf;
  logic          rx_unf;
  logic          wait_to;
  logic          wait_to_set;
  logic          irq_rx_en;
  logic          irq_txe_en;
  logic [7:0]    scratch;

  logic [7:0]    status_byte;
  logic [7:0]    ctrl_byte;
  logic [7:0]    rd_mux;

  assign access      = PSEL & PENABLE;
  assign commit      = access & ready;
  assign wr_commit   = commit & PWRITE;
  assign rd_commit   = commit & ~PWRITE;
  assign PREADY      = ready;

  assign sel_data    = (PADDR == ADDR_DATA);
  assign sel_status  = (PADDR == ADDR_STATUS);
  assign sel_ctrl    = (PADDR == ADDR_CTRL);
  assign sel_scratch = (PADDR == ADDR_SCRATCH);

`ifdef APB_MAILBOX_WAIT_EN
  // Limits above the counter range collapse onto the saturation value.
  localparam logic [7:0] LIMIT = (WAIT_LIMIT > 255) ? 8'hFF : 8'(WAIT_LIMIT);

  logic       stall;
  logic [7:0] wait_cnt;

  // Stall only a DATA access that cannot proceed; once the limit is reached
  // PREADY is forced and the access falls through to the drop/underflow path.
  assign stall       = access & sel_data & (PWRITE ? tx_full : rx_empty);
  assign ready       = ~stall | (wait_cnt >= LIMIT);
  assign wait_to_set = commit & stall;

  // Counts stalled access-phase cycles; restarts at every setup phase.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wait_cnt <= '0;
    end else if (PSEL && !PENABLE) begin
      wait_cnt <= '0;
    end else if (access && !ready && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign ready       = 1'b1;
  assign wait_to_set = 1'b0;

  // The stall bound only matters when stalling is built in.
  if (WAIT_LIMIT < 0) begin : g_wait_limit_unused
  end
`endif

  // TX: host pushes on DATA writes, core pops the head. The head is hidden
  // during the flush cycle so the core never takes a byte being discarded.
  assign tx_push  = wr_commit & sel_data;
  assign tx_valid = ~tx_empty & ~tx_flush_pend;
  assign tx_pop   = tx_valid & tx_ready;

  byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .flush (tx_flush_pend),
    .push  (tx_push),
    .wdata (PWDATA),
    .pop   (tx_pop),
    .rdata (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  // RX: core pushes when there is room, host pops on DATA reads.
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = rd_commit & sel_data;

  byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .flush (rx_flush_pend),
    .push  (rx_push),
    .wdata (rx_data),
    .pop   (rx_pop),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  // CTRL enables, SCRATCH, and the one-cycle flush requests. A flush bit is
  // never stored, so CTRL reads those bits back as 0.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      irq_rx_en     <= RST_CTRL_EN;
      irq_txe_en    <= RST_CTRL_EN;
      tx_flush_pend <= 1'b0;
      rx_flush_pend <= 1'b0;
      scratch       <= RST_SCRATCH;
    end else begin
      tx_flush_pend <= wr_commit & sel_ctrl & PWDATA[CTRL_TX_FLUSH];
      rx_flush_pend <= wr_commit & sel_ctrl & PWDATA[CTRL_RX_FLUSH];
      if (wr_commit && sel_ctrl) begin
        irq_rx_en  <= PWDATA[CTRL_IRQ_RX_EN];
        irq_txe_en <= PWDATA[CTRL_IRQ_TXE_EN];
      end
      if (wr_commit && sel_scratch) begin
        scratch <= PWDATA;
      end
    end
  end

  // Sticky error flags, cleared by writing 1 to their STATUS bit.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tx_ovf  <= RST_FLAG;
      rx_unf  <= RST_FLAG;
      wait_to <= RST_FLAG;
    end else begin
      if (wr_commit && sel_data && tx_full) begin
        tx_ovf <= 1'b1;
      end else if (wr_commit && sel_status && PWDATA[ST_TX_OVF]) begin
        tx_ovf <= 1'b0;
      end
      if (rd_commit && sel_data && rx_empty) begin
        rx_unf <= 1'b1;
      end else if (wr_commit && sel_status && PWDATA[ST_RX_UNF]) begin
        rx_unf <= 1'b0;
      end
      if (wait_to_set) begin
        wait_to <= 1'b1;
      end else if (wr_commit && sel_status && PWDATA[ST_WAIT_TO]) begin
        wait_to <= 1'b0;
      end
    end
  end

  // Interrupt is registered, so it trails its sources by one cycle.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      irq <= RST_IRQ;
    end else begin
      irq <= (irq_rx_en & ~rx_empty) | (irq_txe_en & tx_empty) | tx_ovf | rx_unf | wait_to;
    end
  end

  // Assemble STATUS and CTRL read views.
  always_comb begin
    status_byte              = '0;
    status_byte[ST_TX_FULL]  = tx_full;
    status_byte[ST_TX_EMPTY] = tx_empty;
    status_byte[ST_RX_FULL]  = rx_full;
    status_byte[ST_RX_EMPTY] = rx_empty;
    status_byte[ST_TX_OVF]   = tx_ovf;
    status_byte[ST_RX_UNF]   = rx_unf;
    status_byte[ST_WAIT_TO]  = wait_to;

    ctrl_byte                  = '0;
    ctrl_byte[CTRL_IRQ_RX_EN]  = irq_rx_en;
    ctrl_byte[CTRL_IRQ_TXE_EN] = irq_txe_en;
  end

  // Read mux; unmapped addresses and the idle bus read as 0. An empty RX
  // returns 0 rather than a stale head.
  always_comb begin
    rd_mux = '0;
    case (PADDR)
      ADDR_DATA:     rd_mux = rx_empty ? 8'h00 : rx_head;
      ADDR_STATUS:   rd_mux = status_byte;
      ADDR_TX_LEVEL: rd_mux = 8'(tx_level);
      ADDR_RX_LEVEL: rd_mux = 8'(rx_level);
      ADDR_CTRL:     rd_mux = ctrl_byte;
      ADDR_SCRATCH:  rd_mux = scratch;
      ADDR_ID:       rd_mux = ID_VALUE;
      default:       rd_mux = '0;
    endcase
  end

  assign PRDATA = access ? rd_mux : 8'h00;

endmodule

// File: tb/tb_apb_mailbox.sv
// ---------------------------------------------------------------------------
// tb_apb_mailbox
// Directed self-checking bench for apb_mailbox (DEPTH=4, ID=0xA5,
// WAIT_LIMIT=255). Define APB_MAILBOX_WAIT_EN to exercise the stall path.
// ---------------------------------------------------------------------------
module tb_apb_mailbox;

  localparam logic [4:0] A_DATA     = 5'h00;
  localparam logic [4:0] A_STATUS   = 5'h01;
  localparam logic [4:0] A_TX_LEVEL = 5'h02;
  localparam logic [4:0] A_RX_LEVEL = 5'h03;
  localparam logic [4:0] A_CTRL     = 5'h04;
  localparam logic [4:0] A_SCRATCH  = 5'h05;
  localparam logic [4:0] A_ID       = 5'h06;
  localparam int         STALL_BOUND = 400;

`ifdef APB_MAILBOX_WAIT_EN
  localparam logic [7:0] WT_BIT = 8'h40;
`else
  localparam logic [7:0] WT_BIT = 8'h00;
`endif

  logic       CLK;
  logic       RESETn;
  logic       PSEL;
  logic [4:0] PADDR;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       irq;

  int checkCount = 0;
  int errorCount = 0;
  logic [7:0] txExpect [$];

  apb_mailbox #(
    .DEPTH      (4),
    .ID_VALUE   (8'hA5),
    .WAIT_LIMIT (255)
  ) dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .PSEL     (PSEL),
    .PADDR    (PADDR),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .irq      (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full APB transfer; reports the number of stalled access cycles.
  task automatic apbAccess(input logic wr, input logic [4:0] addr, input logic [7:0] wdata,
                           output logic [7:0] rdata, output int stall);
    int n;
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!PREADY && n < STALL_BOUND) begin
      @(negedge CLK);
      n++;
    end
    if (n >= STALL_BOUND) checkOutput("pready_bound", PREADY, 1);
    rdata = PRDATA;
    stall = n;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apbWrite(input logic [4:0] addr, input logic [7:0] data);
    logic [7:0] unused;
    int stall;
    apbAccess(1'b1, addr, data, unused, stall);
  endtask

  task automatic readCheck(input string tag, input logic [4:0] addr, input logic [7:0] expected);
    logic [7:0] data;
    int stall;
    apbAccess(1'b0, addr, 8'h00, data, stall);
    checkOutput(tag, data, expected);
  endtask

  // Core offers one RX byte for a single cycle.
  task automatic applyStimulus(input logic [7:0] data);
    @(posedge CLK); #1;
    rx_valid = 1'b1; rx_data = data;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  // Hold tx_ready and expect txExpect in order, then an empty stream.
  task automatic drainTx(input string tag);
    @(posedge CLK); #1;
    tx_ready = 1'b1;
    foreach (txExpect[i]) begin
      @(negedge CLK);
      checkOutput({tag, "_valid"}, tx_valid, 1);
      checkOutput({tag, "_data"}, tx_data, txExpect[i]);
    end
    @(negedge CLK);
    checkOutput({tag, "_done"}, tx_valid, 0);
    tx_ready = 1'b0;
    txExpect.delete();
  endtask

  initial begin
    logic [7:0] rd;
    int stall;

    RESETn = 1'b0; PSEL = 1'b0; PADDR = '0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_prdata", PRDATA, 0);
    checkOutput("rst_pready", PREADY, 1);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_rx_ready", rx_ready, 1);
    checkOutput("rst_irq", irq, 0);
    @(posedge CLK); #1;
    RESETn = 1'b1;
    readCheck("rst_status", A_STATUS, 8'h0A);
    readCheck("rst_ctrl", A_CTRL, 8'h00);
    readCheck("rst_scratch", A_SCRATCH, 8'h00);

    // TX path: three bytes then stream them out
    apbWrite(A_DATA, 8'h11);
    apbWrite(A_DATA, 8'h22);
    apbWrite(A_DATA, 8'h33);
    readCheck("tx_level3", A_TX_LEVEL, 8'h03);
    txExpect = '{8'h11, 8'h22, 8'h33};
    drainTx("tx3");

    // RX path with underflow
    applyStimulus(8'h5A);
    applyStimulus(8'hC3);
    readCheck("rx_level2", A_RX_LEVEL, 8'h02);
    readCheck("rx_read0", A_DATA, 8'h5A);
    readCheck("rx_read1", A_DATA, 8'hC3);
    readCheck("rx_underflow", A_DATA, 8'h00);
    readCheck("status_unf", A_STATUS, 8'h2A | WT_BIT);
    checkOutput("irq_unf", irq, 1);
    apbWrite(A_STATUS, 8'h60);
    readCheck("status_unf_clr", A_STATUS, 8'h0A);
    checkOutput("irq_unf_clr", irq, 0);

    // TX overflow at DEPTH
    for (int i = 0; i < 5; i++) apbWrite(A_DATA, 8'hA1 + 8'(i));
    readCheck("tx_level_full", A_TX_LEVEL, 8'h04);
    readCheck("status_ovf", A_STATUS, 8'h19 | WT_BIT);
    checkOutput("irq_ovf", irq, 1);
    txExpect = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    drainTx("tx_ovf");
    apbWrite(A_STATUS, 8'h50);
    readCheck("status_ovf_clr", A_STATUS, 8'h0A);

    // RX interrupt and RX flush
    apbWrite(A_CTRL, 8'h04);
    checkOutput("irq_idle", irq, 0);
    applyStimulus(8'hE7);
    @(negedge CLK);
    checkOutput("irq_rx_lag", irq, 0);
    @(negedge CLK);
    checkOutput("irq_rx_rise", irq, 1);
    apbWrite(A_CTRL, 8'h06);
    readCheck("rx_flush_level", A_RX_LEVEL, 8'h00);
    checkOutput("irq_rx_fall", irq, 0);
    readCheck("ctrl_after_rxflush", A_CTRL, 8'h04);

    // TX flush and TX-empty interrupt
    apbWrite(A_DATA, 8'h01);
    apbWrite(A_DATA, 8'h02);
    apbWrite(A_CTRL, 8'h05);
    readCheck("tx_flush_level", A_TX_LEVEL, 8'h00);
    checkOutput("tx_flush_valid", tx_valid, 0);
    readCheck("ctrl_after_txflush", A_CTRL, 8'h04);
    apbWrite(A_CTRL, 8'h08);
    readCheck("ctrl_txe", A_CTRL, 8'h08);
    checkOutput("irq_txe", irq, 1);
    apbWrite(A_CTRL, 8'h00);
    readCheck("ctrl_zero", A_CTRL, 8'h00);
    checkOutput("irq_txe_off", irq, 0);

    // Scratch, ID, unmapped
    apbWrite(A_SCRATCH, 8'h9C);
    readCheck("scratch", A_SCRATCH, 8'h9C);
    readCheck("id", A_ID, 8'hA5);
    apbWrite(5'h1F, 8'hFF);
    readCheck("unmapped", 5'h1F, 8'h00);
    readCheck("scratch_kept", A_SCRATCH, 8'h9C);

    // Reset during an access phase
    apbWrite(A_CTRL, 8'h04);
    apbWrite(A_DATA, 8'h42);
    applyStimulus(8'h3C);
    readCheck("pre_rst_rx_level", A_RX_LEVEL, 8'h01);
    checkOutput("pre_rst_irq", irq, 1);
    checkOutput("pre_rst_tx_valid", tx_valid, 1);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_DATA; PWDATA = 8'h99;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    checkOutput("midrst_pready", PREADY, 1);
    checkOutput("midrst_tx_valid", tx_valid, 0);
    checkOutput("midrst_rx_ready", rx_ready, 1);
    checkOutput("midrst_irq", irq, 0);
    checkOutput("midrst_prdata", PRDATA, 0);
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(posedge CLK); #1;
    RESETn = 1'b1;
    readCheck("post_rst_status", A_STATUS, 8'h0A);
    readCheck("post_rst_tx_level", A_TX_LEVEL, 8'h00);
    readCheck("post_rst_rx_level", A_RX_LEVEL, 8'h00);
    readCheck("post_rst_ctrl", A_CTRL, 8'h00);
    readCheck("post_rst_scratch", A_SCRATCH, 8'h00);

`ifdef APB_MAILBOX_WAIT_EN
    // Blocked read released by a core push
    begin
      int lowCycles;
      lowCycles = 0;
      @(posedge CLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_DATA;
      @(posedge CLK); #1;
      PENABLE = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        if (!PREADY) lowCycles++;
      end
      checkOutput("wait_rd_stall", lowCycles, 10);
      applyStimulus(8'h77);
      @(negedge CLK);
      checkOutput("wait_rd_ready", PREADY, 1);
      checkOutput("wait_rd_data", PRDATA, 8'h77);
      @(posedge CLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      readCheck("wait_rd_level", A_RX_LEVEL, 8'h00);
      readCheck("wait_rd_status", A_STATUS, 8'h0A);
    end

    // Blocked read with no data times out
    apbAccess(1'b0, A_DATA, 8'h00, rd, stall);
    checkOutput("wait_to_stall", stall, 255);
    checkOutput("wait_to_data", rd, 8'h00);
    readCheck("wait_to_status", A_STATUS, 8'h6A);
    checkOutput("wait_to_irq", irq, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
